// File: rtl/shift_issue_queue.sv
// Request FIFO and issue stage in front of the external pipelined shifter/rotator.
// A latency-matched valid/tag delay line re-pairs each shifter result with its tag.
module shift_issue_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 5,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [4:0]               in_sel,
  input  logic                     in_rotate,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [31:0]              sh_a,
  output logic [4:0]               sh_sel,
  output logic                     sh_rotate,
  input  logic [31:0]              sh_b,
  output logic                     out_valid,
  output logic [31:0]              out_b,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      mem_a   [DEPTH];
  logic [4:0]       mem_sel [DEPTH];
  logic             mem_rot [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [LATENCY-1:0] dl_valid;
  logic [TAG_W-1:0]   dl_tag [LATENCY];

  logic push;
  logic pop;

  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (count != '0);
  assign busy     = (count != '0) | (|dl_valid);

  // Payload storage carries no reset; only pointers and count qualify it.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_a[wr_ptr]   <= in_a;
      mem_sel[wr_ptr] <= in_sel;
      mem_rot[wr_ptr] <= in_rotate;
      mem_tag[wr_ptr] <= in_tag;
    end
  end

  // Pointers and occupancy; the head is popped every cycle the FIFO is non-empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue registers toward the shifter; they only move on an issue edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_a      <= '0;
      sh_sel    <= '0;
      sh_rotate <= 1'b0;
    end else if (pop) begin
      sh_a      <= mem_a[rd_ptr];
      sh_sel    <= mem_sel[rd_ptr];
      sh_rotate <= mem_rot[rd_ptr];
    end
  end

  // Valid/tag delay line matched to the shifter latency; never stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dl_valid <= '0;
      for (int i = 0; i < int'(LATENCY); i++) dl_tag[i] <= '0;
    end else begin
      dl_valid[0] <= pop;
      if (pop) dl_tag[0] <= mem_tag[rd_ptr];
      for (int i = 1; i < int'(LATENCY); i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_tag[i]   <= dl_tag[i-1];
      end
    end
  end

  // Result capture: one-cycle pulse, data and tag hold between results.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_b     <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= dl_valid[LATENCY-1];
      if (dl_valid[LATENCY-1]) begin
        out_b   <= sh_b;
        out_tag <= dl_tag[LATENCY-1];
      end
    end
  end

endmodule

// File: tb/tb_shift_issue_queue.sv
// Directed bench for shift_issue_queue with a behavioural rotate/shift pipeline
// standing in for the external shifter (DEPTH=4 main instance, DEPTH=2 full-check instance).
module tb_shift_issue_queue;

  localparam int unsigned LAT = 5;
  localparam int unsigned TW  = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;

  logic          in_valid, in_ready, in_rotate, sh_rotate, out_valid, busy;
  logic [31:0]   in_a, sh_a, sh_b, out_b;
  logic [4:0]    in_sel, sh_sel;
  logic [TW-1:0] in_tag, out_tag;
  logic [2:0]    count;

  logic          in_valid2, in_ready2, in_rotate2, sh_rotate2, out_valid2, busy2;
  logic [31:0]   in_a2, sh_a2, sh_b2, out_b2;
  logic [4:0]    in_sel2, sh_sel2;
  logic [TW-1:0] in_tag2, out_tag2;
  logic [1:0]    count2;

  shift_issue_queue #(.DEPTH(4), .LATENCY(LAT), .TAG_W(TW)) u_dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_sel(in_sel), .in_rotate(in_rotate), .in_tag(in_tag),
    .sh_a(sh_a), .sh_sel(sh_sel), .sh_rotate(sh_rotate), .sh_b(sh_b),
    .out_valid(out_valid), .out_b(out_b), .out_tag(out_tag), .count(count), .busy(busy)
  );

  shift_issue_queue #(.DEPTH(2), .LATENCY(LAT), .TAG_W(TW)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_sel(in_sel2), .in_rotate(in_rotate2), .in_tag(in_tag2),
    .sh_a(sh_a2), .sh_sel(sh_sel2), .sh_rotate(sh_rotate2), .sh_b(sh_b2),
    .out_valid(out_valid2), .out_b(out_b2), .out_tag(out_tag2), .count(count2), .busy(busy2)
  );

  function automatic logic [31:0] shf(input logic [31:0] a, input logic [4:0] s, input logic r);
    logic [63:0] d;
    d = {a, a} << s;
    return r ? d[63:32] : (a << s);
  endfunction

  // Shifter stand-in: sh_* registered at edge k yields sh_b sampled at edge k+LAT.
  logic [31:0] pipe1 [LAT-1];
  logic [31:0] pipe2 [LAT-1];
  always @(posedge clock) begin
    pipe1[0] <= shf(sh_a, sh_sel, sh_rotate);
    pipe2[0] <= shf(sh_a2, sh_sel2, sh_rotate2);
    for (int i = 1; i < int'(LAT) - 1; i++) begin
      pipe1[i] <= pipe1[i-1];
      pipe2[i] <= pipe2[i-1];
    end
  end
  assign sh_b  = pipe1[LAT-2];
  assign sh_b2 = pipe2[LAT-2];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0]   q_b   [$];
  logic [TW-1:0] q_tag [$];
  int            q_cyc [$];
  int            maxcnt = 0;
  bit            rdy_low = 1'b0;
  bit            saw_e = 1'b0;

  always @(negedge clock) begin
    if (out_valid) begin
      q_b.push_back(out_b);
      q_tag.push_back(out_tag);
      q_cyc.push_back(cyc);
    end
    if (int'(count) > maxcnt) maxcnt = int'(count);
    if (!in_ready) rdy_low = 1'b1;
    if (out_valid2 && out_tag2 == 4'hE) saw_e = 1'b1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_out(input int n, input int bound);
    int k;
    k = 0;
    while (q_tag.size() < n && k < bound) begin
      @(negedge clock);
      k++;
    end
    @(negedge clock);
    check("out_count", 32'(q_tag.size()), 32'(n));
  endtask

  task automatic clear_q();
    q_b.delete();
    q_tag.delete();
    q_cyc.delete();
    maxcnt  = 0;
    rdy_low = 1'b0;
  endtask

  int c0;

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_sel = '0; in_rotate = 1'b0; in_tag = '0;
    in_valid2 = 1'b0; in_a2 = '0; in_sel2 = '0; in_rotate2 = 1'b0; in_tag2 = '0;
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    reset_n = 1'b1;
    clear_q();

    // Idle after reset
    repeat (10) @(negedge clock);
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_count", 32'(count), 32'd0);
    check("idle_busy",  32'(busy), 32'd0);
    check("idle_sh_a",  sh_a, 32'd0);
    check("idle_noout", 32'(q_tag.size()), 32'd0);

    // Single rotate request
    c0 = cyc;
    in_valid = 1'b1; in_a = 32'h0000_001F; in_sel = 5'd5; in_rotate = 1'b1; in_tag = 4'd3;
    @(negedge clock);
    in_valid = 1'b0;
    check("single_cnt1", 32'(count), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    @(negedge clock);
    check("single_sh_a",   sh_a, 32'h0000_001F);
    check("single_sh_sel", 32'(sh_sel), 32'd5);
    check("single_sh_rot", 32'(sh_rotate), 32'd1);
    check("single_cnt0",   32'(count), 32'd0);
    wait_out(1, 20);
    if (q_tag.size() >= 1) begin
      check("single_b",   q_b[0], 32'h0000_03E0);
      check("single_tag", 32'(q_tag[0]), 32'd3);
      check("single_lat", 32'(q_cyc[0]), 32'(c0 + 7));
    end
    repeat (5) @(negedge clock);
    check("single_once", 32'(q_tag.size()), 32'd1);
    check("single_hold_b", out_b, 32'h0000_03E0);
    check("single_idle_busy", 32'(busy), 32'd0);

    // Back-to-back: six rotate requests on consecutive cycles
    clear_q();
    c0 = cyc;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = (32'h20 << i) - 32'd1; in_sel = 5'd5; in_rotate = 1'b1;
      in_tag = TW'(i);
      @(negedge clock);
    end
    in_valid = 1'b0;
    wait_out(6, 30);
    for (int i = 0; i < q_tag.size(); i++) begin
      check($sformatf("b2b_tag%0d", i), 32'(q_tag[i]), 32'(i));
      check($sformatf("b2b_b%0d", i), q_b[i], ((32'h20 << i) - 32'd1) << 5);
      check($sformatf("b2b_cyc%0d", i), 32'(q_cyc[i]), 32'(c0 + 7 + i));
    end
    check("b2b_maxcnt", 32'(maxcnt), 32'd1);

    // Sustained fill: eight logical shifts, drain keeps pace
    repeat (3) @(negedge clock);
    clear_q();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = 32'h8000_0001; in_sel = 5'd1; in_rotate = 1'b0;
      in_tag = TW'(i);
      @(negedge clock);
    end
    in_valid = 1'b0;
    wait_out(8, 30);
    for (int i = 0; i < q_tag.size(); i++) begin
      check($sformatf("fill_b%0d", i), q_b[i], 32'h0000_0002);
      check($sformatf("fill_tag%0d", i), 32'(q_tag[i]), 32'(i));
    end
    check("fill_rdy_low", 32'(rdy_low), 32'd0);
    check("fill_maxcnt",  32'(maxcnt), 32'd1);

    // Full: DEPTH=2 instance with occupancy pinned at 2
    in_valid2 = 1'b1; in_a2 = 32'h1; in_sel2 = 5'd0; in_rotate2 = 1'b0; in_tag2 = 4'd1;
    @(negedge clock);
    in_tag2 = 4'd2;
    @(negedge clock);
    in_valid2 = 1'b0;
    repeat (12) @(negedge clock);
    check("full_pre_cnt", 32'(count2), 32'd0);
    check("full_pre_rdy", 32'(in_ready2), 32'd1);
    saw_e = 1'b0;
    force u_dut2.count = 2'd2;
    #1;
    check("full_ready", 32'(in_ready2), 32'd0);
    in_valid2 = 1'b1; in_a2 = 32'hDEAD_BEEF; in_tag2 = 4'hE;
    @(negedge clock);
    release u_dut2.count;
    in_valid2 = 1'b0;
    repeat (15) @(negedge clock);
    check("full_no_tagE", 32'(saw_e), 32'd0);
    check("full_drained", 32'(count2), 32'd0);
    check("full_idle",    32'(busy2), 32'd0);

    // Reset while three requests are in flight
    clear_q();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'h0000_0F00; in_sel = 5'd4; in_rotate = 1'b1;
      in_tag = TW'(7 + i);
      @(negedge clock);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rdy",   32'(in_ready), 32'd1);
    check("mid_cnt",   32'(count), 32'd0);
    check("mid_busy0", 32'(busy), 32'd0);
    check("mid_sh_a",  sh_a, 32'd0);
    check("mid_sh_sel", 32'(sh_sel), 32'd0);
    check("mid_sh_rot", 32'(sh_rotate), 32'd0);
    check("mid_ov",    32'(out_valid), 32'd0);
    check("mid_ob",    out_b, 32'd0);
    check("mid_otag",  32'(out_tag), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    clear_q();
    repeat (15) @(negedge clock);
    check("post_rst_noout", 32'(q_tag.size()), 32'd0);
    check("post_rst_busy",  32'(busy), 32'd0);
    check("post_rst_cnt",   32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
